// File: rtl/accum_alu.sv
// Sequential accumulator ALU: one-cycle logic/add/sub/load ops, plus iterative
// shift-add multiply and restoring divide/modulo using the accumulator as operand B.
module accum_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_code,
  input  logic [WIDTH-1:0]   input1,
  output logic [2*WIDTH-1:0] output1,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err_code
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_ONES = 4'd12;
  localparam logic [3:0] OP_ZERO = 4'd13;
  localparam logic [3:0] OP_LOAD = 4'd14;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;     // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [2*WIDTH-1:0] b_q, b_d;     // multiplicand (shifts left) or divisor (static)
  logic [2*WIDTH-1:0] p_q, p_d;     // partial product or partial remainder

  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] single_res;
  logic               single_err0;

  logic [2*WIDTH-1:0] mul_p_step;
  logic [WIDTH:0]     rem_sh, rem_new;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_step;

  assign b_op = acc_q[WIDTH-1:0];
  assign sum  = {1'b0, input1} + {1'b0, b_op};
  assign diff = {1'b0, input1} - {1'b0, b_op};

  assign mul_p_step = a_q[0] ? (p_q + b_q) : p_q;

  // Restoring division: shift the next dividend bit into the remainder, subtract if it fits.
  assign rem_sh   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, b_q[WIDTH-1:0]});
  assign rem_new  = rem_ge ? (rem_sh - {1'b0, b_q[WIDTH-1:0]}) : rem_sh;
  assign quo_step = {a_q[WIDTH-2:0], rem_ge};

  always_comb begin
    single_res  = acc_q;
    single_err0 = 1'b0;
    case (op_code)
      OP_ADD: begin
        single_res  = {{(WIDTH-1){1'b0}}, sum};
        single_err0 = sum[WIDTH];
      end
      OP_SUB: begin
        single_res  = {{(WIDTH-1){diff[WIDTH]}}, diff};
        single_err0 = diff[WIDTH];
      end
      OP_AND:  single_res = {{WIDTH{1'b0}}, input1 & b_op};
      OP_OR:   single_res = {{WIDTH{1'b0}}, input1 | b_op};
      OP_NAND: single_res = {{WIDTH{1'b0}}, ~(input1 & b_op)};
      OP_NOR:  single_res = {{WIDTH{1'b0}}, ~(input1 | b_op)};
      OP_XOR:  single_res = {{WIDTH{1'b0}}, input1 ^ b_op};
      OP_XNOR: single_res = {{WIDTH{1'b0}}, ~(input1 ^ b_op)};
      OP_NOT:  single_res = {{WIDTH{1'b0}}, ~input1};
      OP_ONES: single_res = {(2*WIDTH){1'b1}};
      OP_ZERO: single_res = '0;
      OP_LOAD: single_res = {{WIDTH{1'b0}}, input1};
      default: single_res = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_code == OP_MUL || ((op_code == OP_DIV || op_code == OP_MOD) && b_op != '0)) begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = CW'(WIDTH);
            op_d    = op_code;
            a_d     = input1;
            b_d     = {{WIDTH{1'b0}}, b_op};
            p_d     = '0;
          end else if (op_code == OP_DIV || op_code == OP_MOD) begin
            err_d  = 2'b10;
            done_d = 1'b1;
          end else begin
            acc_d  = single_res;
            err_d  = {1'b0, single_err0};
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          p_d = mul_p_step;
          b_d = b_q << 1;
          a_d = a_q >> 1;
        end else begin
          p_d = {{(WIDTH-1){1'b0}}, rem_new};
          a_d = quo_step;
        end
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 2'b00;
          if (op_q == OP_MUL)      acc_d = mul_p_step;
          else if (op_q == OP_DIV) acc_d = {{WIDTH{1'b0}}, quo_step};
          else                     acc_d = {{(WIDTH-1){1'b0}}, rem_new};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
    end
  end

  assign output1  = acc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_code = err_q;
endmodule

// File: tb/tb_accum_alu.sv
// Directed-vector bench for accum_alu with hand-computed expectations.
module tb_accum_alu;
  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [3:0]         op_code;
  logic [WIDTH-1:0]   input1;
  logic [2*WIDTH-1:0] output1;
  logic               busy;
  logic               done;
  logic [1:0]         err_code;

  int vectors = 0;
  int miscompares = 0;

  accum_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code), .input1(input1),
    .output1(output1), .busy(busy), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("vector %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
  endtask

  // Single-cycle op: after the accept edge, done must be high and busy low.
  task automatic op1(input logic [3:0] op, input logic [WIDTH-1:0] a);
    start = 1'b1; op_code = op; input1 = a;
    tick();
    start = 1'b0; op_code = 4'd15; input1 = '0;
  endtask

  // Multi-cycle op: returns the number of edges busy stayed high after accept.
  task automatic op_multi(input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic inject, output int cycles);
    op1(op, a);
    check("multi_busy_after_accept", busy, 1);
    check("multi_done_low_after_accept", done, 0);
    cycles = 0;
    while (busy && cycles < 40) begin
      if (inject && cycles == 8) begin
        start = 1'b1; op_code = 4'd13; input1 = 16'h1234;
      end
      tick();
      start = 1'b0;
      cycles++;
    end
  endtask

  int cyc;
  int done_seen;

  initial begin
    rst = 1'b1; start = 1'b0; op_code = 4'd15; input1 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_output1", output1, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_code, 0);

    // 1: LOAD then ADD
    op1(4'd14, 16'd15);
    check("load15_out", output1, 15);
    op1(4'd0, 16'd11);
    check("add_out", output1, 26);
    check("add_done", done, 1);
    check("add_err", err_code, 0);
    check("add_busy", busy, 0);
    tick();
    check("add_done_one_cycle", done, 0);

    // 2: SUB with borrow; ADD with carry
    op1(4'd14, 16'd15);
    op1(4'd1, 16'd11);
    check("sub_out", output1, 32'hFFFF_FFFC);
    check("sub_err", err_code, 2'b01);
    op1(4'd14, 16'd1000);
    check("load_clears_err", err_code, 0);
    op1(4'd0, 16'd65000);
    check("add_carry_out", output1, 32'h0001_01D0);
    check("add_carry_err", err_code, 2'b01);

    // Bitwise and constant ops
    op1(4'd14, 16'h00F0);
    op1(4'd9, 16'h0FF0);
    check("xor_out", output1, 32'h0000_0F00);
    op1(4'd7, 16'hFFFF);
    check("nand_out", output1, 32'h0000_F0FF);
    op1(4'd11, 16'h00FF);
    check("not_out", output1, 32'h0000_FF00);
    op1(4'd12, 16'h0000);
    check("ones_out", output1, 32'hFFFF_FFFF);
    op1(4'd15, 16'h5555);
    check("nop_holds", output1, 32'hFFFF_FFFF);
    check("nop_done", done, 1);
    op1(4'd13, 16'h5555);
    check("zero_out", output1, 0);

    // 3: MUL with ignored mid-run start
    op1(4'd14, 16'd15);
    op_multi(4'd2, 16'd32000, 1'b1, cyc);
    check("mul_cycles", cyc, 16);
    check("mul_out", output1, 480000);
    check("mul_done", done, 1);
    check("mul_err", err_code, 0);
    tick();
    check("mul_midrun_start_ignored", output1, 480000);

    // 4: DIV and MOD
    op1(4'd14, 16'd7);
    op_multi(4'd3, 16'd100, 1'b0, cyc);
    check("div_cycles", cyc, 16);
    check("div_out", output1, 14);
    op1(4'd14, 16'd7);
    op_multi(4'd4, 16'd100, 1'b0, cyc);
    check("mod_out", output1, 2);
    check("mod_err", err_code, 0);
    check("mod_done", done, 1);

    // 5: divide / modulo by zero, issued back-to-back in the done cycle
    op1(4'd14, 16'd0);
    op1(4'd3, 16'd11);
    check("div0_busy", busy, 0);
    check("div0_out", output1, 0);
    check("div0_err", err_code, 2'b10);
    check("div0_done", done, 1);
    op1(4'd4, 16'd11);
    check("mod0_busy", busy, 0);
    check("mod0_out", output1, 0);
    check("mod0_err", err_code, 2'b10);
    check("mod0_done", done, 1);

    // 6: reset aborts MUL; reset beats start
    op1(4'd14, 16'd3);
    op1(4'd2, 16'd5);
    check("abort_mul_busy", busy, 1);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", output1, 0);
    check("abort_err", err_code, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    op1(4'd14, 16'd9);
    rst = 1'b1; start = 1'b1; op_code = 4'd14; input1 = 16'd5;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_out", output1, 0);
    check("rst_start_done", done, 0);
    tick();
    check("rst_start_no_done", done, 0);
    check("rst_start_out_hold", output1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/accum_alu.md
Name: accum_alu

Overview:
Parametrised sequential successor to the 16-bit combinational ALU breadboard. It provides a registered 2*WIDTH accumulator that supplies operand B, so the accumulator feedback path is complete. Multiply, divide and modulo are iterative and take WIDTH cycles; all other ops complete in one cycle. The block sits between operand and opcode sources and the result and status consumers, using a start/busy/done handshake.

Parameters:
WIDTH, 16, operand width; accumulator and output are 2*WIDTH wide.

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op_code  input  4  operation select; sampled at accept
input1  input  WIDTH  operand A; sampled at accept
output1  output  2*WIDTH  accumulator contents
busy  output  1  high while a multi-cycle op is in progress
done  output  1  one-cycle pulse; high in the cycle in which the new output1/err_code are visible
err_code  output  2  bit0 = add carry-out or sub borrow; bit1 = divide/modulo by zero

Behaviour:
- Reset (rst=1 at an edge): output1=0, busy=0, done=0, err_code=00, FSM=IDLE. Any in-flight op is aborted and its result discarded. rst has priority over start.
- Operand B = output1[WIDTH-1:0] as held at the accept edge.
- Accept: start=1 and busy=0 at an edge. Start while busy=1 is ignored, not queued. op_code and input1 changes after accept are ignored.
- Single-cycle ops (accepted at edge k): output1 and err_code are updated at edge k; done=1 for the cycle following edge k; busy stays 0.
- Op 0 ADD: output1 = zero-extended A+B (WIDTH+1 bits); err0 = carry out of bit WIDTH-1.
- Op 1 SUB: output1 = sign-extended (WIDTH+1)-bit result of {0,A}-{0,B}; err0 = borrow (B>A).
- Op 5–10 AND/OR/NAND/NOR/XOR/XNOR: bitwise on A,B, zero-extended to 2*WIDTH.
- Op 11 NOT: ~A, zero-extended.
- Op 12: output1 = all ones.
- Op 13: output1 = 0.
- Op 14 LOAD: output1 = zero-extended A.
- Op 15: no-op; output1 holds and done still pulses.
- Every completion rewrites err_code; bits not applicable to the completing op are written 0. err_code holds between completions.
- Op 2 MUL (unsigned shift-add, one bit per cycle):
  - Accept edge k: busy=1, FSM=RUN, counter=WIDTH.
  - The counter decrements each edge. At edge k+WIDTH: output1 = A*B (full 2*WIDTH bits), busy=0, err=00.
  - done is high in cycle k+WIDTH (i.e. after edge k+WIDTH).
- Op 3 DIV / Op 4 MOD (unsigned restoring, one quotient bit per cycle):
  - Same timing as MUL.
  - DIV: output1 = zero-extended A/B.
  - MOD: output1 = zero-extended A%B.
- B=0 on DIV or MOD:
  - No iteration and busy never asserts; the op completes as a single-cycle op.
  - output1 is unchanged and err_code = 10.
- FSM states and transitions:
  - IDLE: accept of op 2/3/4 with B≠0 -> RUN; all other accepts stay in IDLE.
  - RUN: counter reaches 0 -> IDLE; done pulses.
  - Any state: rst -> IDLE.
- A back-to-back start in the done cycle is accepted, because busy=0 in that cycle.
- Width rule: all arithmetic is unsigned except the SUB result extension; there is no saturation.

Test Plan:
1. Reset, then LOAD A=15, then ADD A=11 -> output1=26, done pulses 1 cycle after the ADD accept, err_code=00, busy never high.
2. acc=15, SUB A=11 -> output1=32'hFFFFFFFC, err_code=01. Then ADD A=65000 with acc=1000 (after LOAD 1000) -> output1=66000 (32'h000101D0), err_code=01.
3. acc=15, MUL A=32000 -> busy high for exactly 16 cycles, output1=480000, done coincident with busy falling, err_code=00. A start pulse mid-run (op 13) is ignored and acc is not cleared.
4. acc=7, DIV A=100 -> output1=14 after 16 cycles. Then LOAD 7, MOD A=100 -> output1=2, err_code=00.
5. acc=0, DIV A=11 -> busy stays 0, output1 stays 0, err_code=10, done pulses next cycle. MOD with B=0 behaves the same.
6. Start MUL, assert rst on cycle 5 of RUN -> next edge: busy=0, done=0, output1=0, err_code=00, and no done pulse follows. rst and start together -> reset wins and the op is not accepted.
